// File: rtl/ram_burst_master_pkg.sv
// Shared definitions for the block-RAM burst master: default widths, op codes
// and the controller state encoding.
package ram_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RD_DRAIN,
        WRITE,
        FILL,
        DONE
    } state_e;

endpackage

// File: rtl/ram_burst_master_if.sv
// Client-side channels of the burst master: command, write-data and read-response.
interface ram_burst_master_if #(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] cmd_fill;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    // Host / DMA side issuing commands and consuming read data
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_fill, wr_valid, wr_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_fill, wr_valid, wr_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port block RAM: read bursts, streamed write
// bursts and constant fills, with synchronous abort.
module ram_burst_master #(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              CLR_n,
    ram_burst_master_if.slave bus,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_clr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    import ram_pkg::*;

    state_e            state;
    state_e            next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] fill_q;
    logic              rd_valid_q;
    logic              rd_last_q;
    logic              cmd_fire;
    logic              last;
    logic              advance;

    assign cmd_fire = bus.cmd_valid && (state == IDLE);
    assign last     = (cnt_q == '0);
    assign advance  = (state == READ) || (state == FILL) ||
                      ((state == WRITE) && bus.wr_valid);

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    case (bus.cmd_op)
                        OP_READ:  next_state = READ;
                        OP_WRITE: next_state = WRITE;
                        OP_FILL:  next_state = FILL;
                        default:  next_state = DONE;
                    endcase
                end
            end
            READ: begin
                if (abort) begin
                    next_state = DONE;
                end else if (last) begin
                    next_state = RD_DRAIN;
                end
            end
            RD_DRAIN: next_state = DONE;
            WRITE: begin
                if (abort || (bus.wr_valid && last)) begin
                    next_state = DONE;
                end
            end
            FILL: begin
                if (abort || last) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address wraps modulo the RAM depth by plain ADDR_W-bit overflow
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            fill_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= (state == READ);
            rd_last_q  <= (state == READ) && last;
            if (cmd_fire) begin
                addr_q <= bus.cmd_addr;
                cnt_q  <= bus.cmd_len;
                fill_q <= bus.cmd_fill;
            end else if (advance) begin
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_clr       = 1'b0;
        ram_addr      = '0;
        ram_di        = '0;
        case (state)
            IDLE: bus.cmd_ready = 1'b1;
            READ: begin
                ram_en   = 1'b1;
                ram_addr = addr_q;
            end
            WRITE: begin
                bus.wr_ready = 1'b1;
                ram_en       = bus.wr_valid;
                ram_we       = bus.wr_valid;
                ram_addr     = addr_q;
                ram_di       = bus.wr_data;
            end
            FILL: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = addr_q;
                ram_di   = fill_q;
            end
            // Clearing DO here keeps stale data from an aborted read off the bus
            DONE:    ram_clr = 1'b1;
            default: ;
        endcase
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.rd_data  = ram_do;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master closed around a behavioural 64x16 block RAM.
module tb_ram_burst_master;

    import ram_pkg::*;

    logic        CLK = 1'b0;
    logic        CLR_n;
    logic        abort;
    logic        busy, done;
    logic        ram_en, ram_we, ram_clr;
    logic [5:0]  ram_addr;
    logic [15:0] ram_di, ram_do;
    logic        preload;
    logic [15:0] mem [0:63];

    ram_burst_master_if bus ();

    ram_burst_master dut (
        .CLK      (CLK),
        .CLR_n    (CLR_n),
        .bus      (bus.slave),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_clr  (ram_clr),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    always #5 CLK = ~CLK;

    // Block RAM: registered read, write leaves DO unchanged, CLR zeroes DO
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'hD000 + 16'(i);
        end else if (ram_clr) begin
            ram_do <= 16'h0000;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            else        ram_do <= mem[ram_addr];
        end
    end

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] rdq [$];
    logic [15:0] wrq [$];
    int          lastIdx, lastCount, doneAt, readyLow, ramAccess, ramWrites, firstValid;
    logic        clrAtDone, busyAt1;
    logic [15:0] doAfter;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Issue one command and run it to completion, recording what the bus did
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] addr,
                                 input logic [5:0] len, input logic [15:0] fill,
                                 input int abortCyc);
        rdq.delete();
        lastIdx = -1; lastCount = 0; doneAt = -1; readyLow = 0;
        ramAccess = 0; ramWrites = 0; firstValid = -1;
        clrAtDone = 1'b0; busyAt1 = 1'b0;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_fill  = fill;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 200 && doneAt < 0; c++) begin
            abort = (c == abortCyc);
            if (wrq.size() > 0 && (c % 3) != 2) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = wrq[0];
            end else begin
                bus.wr_valid = 1'b0;
                bus.wr_data  = 16'h0000;
            end
            #1;
            if (c == 1) busyAt1 = busy;
            if (!bus.cmd_ready) readyLow++;
            if (ram_en) ramAccess++;
            if (ram_en && ram_we) ramWrites++;
            if (bus.rd_valid) begin
                if (firstValid < 0) firstValid = c;
                rdq.push_back(bus.rd_data);
                if (bus.rd_last) begin
                    lastIdx = rdq.size() - 1;
                    lastCount++;
                end
            end
            if (bus.wr_valid && bus.wr_ready) void'(wrq.pop_front());
            if (done) begin
                doneAt    = c;
                clrAtDone = ram_clr;
            end
            tick();
        end
        abort        = 1'b0;
        bus.wr_valid = 1'b0;
        doAfter      = ram_do;
        checkOutput("doneSeen", 32'(doneAt >= 0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] expW [4];
        int          good;
        expW = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        CLR_n = 1'b0; abort = 1'b0; preload = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0;
        bus.cmd_len = '0; bus.cmd_fill = '0; bus.wr_valid = 1'b0; bus.wr_data = '0;
        tick(); tick();
        checkOutput("rstBusy",     32'(busy),         32'd0);
        checkOutput("rstDone",     32'(done),         32'd0);
        checkOutput("rstCmdReady", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rstRdValid",  32'(bus.rd_valid),  32'd0);
        checkOutput("rstRamEn",    32'(ram_en),       32'd0);
        CLR_n = 1'b1;
        tick();

        $display("[TB] fill 0..63 with A5A5");
        applyStimulus(OP_FILL, 6'd0, 6'd63, 16'hA5A5, 0);
        checkOutput("fillDoneAt",   32'(doneAt),    32'd65);
        checkOutput("fillWrites",   32'(ramWrites), 32'd64);
        checkOutput("fillBusy",     32'(busyAt1),   32'd1);
        checkOutput("fillReadyLow", 32'(readyLow),  32'd65);

        $display("[TB] read back 0..63");
        applyStimulus(OP_READ, 6'd0, 6'd63, 16'h0000, 0);
        good = 0;
        foreach (rdq[i]) if (rdq[i] === 16'hA5A5) good++;
        checkOutput("rdCount",    32'(rdq.size()), 32'd64);
        checkOutput("rdMatch",    32'(good),       32'd64);
        checkOutput("rdLastIdx",  32'(lastIdx),    32'd63);
        checkOutput("rdLastCnt",  32'(lastCount),  32'd1);
        checkOutput("rdDoneAt",   32'(doneAt),     32'd66);
        checkOutput("rdFirstVal", 32'(firstValid), 32'd2);

        $display("[TB] wrapping write at 62 with wr_valid gaps");
        wrq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        applyStimulus(OP_WRITE, 6'd62, 6'd3, 16'h0000, 0);
        checkOutput("wrWrites", 32'(ramWrites), 32'd4);
        checkOutput("wrDoneAt", 32'(doneAt),    32'd7);
        checkOutput("wrMem62",  32'(mem[62]),   32'h1111);
        checkOutput("wrMem63",  32'(mem[63]),   32'h2222);
        checkOutput("wrMem0",   32'(mem[0]),    32'h3333);
        checkOutput("wrMem1",   32'(mem[1]),    32'h4444);
        checkOutput("wrMem2",   32'(mem[2]),    32'hA5A5);
        applyStimulus(OP_READ, 6'd62, 6'd3, 16'h0000, 0);
        checkOutput("wrRdCount", 32'(rdq.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("wrRead%0d", i), 32'(rdq[i]), 32'(expW[i]));

        $display("[TB] single-word read at 5");
        applyStimulus(OP_READ, 6'd5, 6'd0, 16'h0000, 0);
        checkOutput("oneCount",    32'(rdq.size()), 32'd1);
        checkOutput("oneData",     32'(rdq[0]),     32'hA5A5);
        checkOutput("oneLastIdx",  32'(lastIdx),    32'd0);
        checkOutput("oneFirstVal", 32'(firstValid), 32'd2);
        checkOutput("oneDoneAt",   32'(doneAt),     32'd3);
        checkOutput("oneReadyLow", 32'(readyLow),   32'd3);

        $display("[TB] abort on 3rd cycle of a 10-word read");
        applyStimulus(OP_READ, 6'd10, 6'd9, 16'h0000, 3);
        checkOutput("abCount",   32'(rdq.size()), 32'd3);
        checkOutput("abDoneAt",  32'(doneAt),     32'd4);
        checkOutput("abClr",     32'(clrAtDone),  32'd1);
        checkOutput("abDoZero",  32'(doAfter),    32'h0000);
        checkOutput("abLastCnt", 32'(lastCount),  32'd0);
        checkOutput("abAccess",  32'(ramAccess),  32'd3);

        $display("[TB] reserved op");
        applyStimulus(OP_NOP, 6'd20, 6'd7, 16'h0000, 0);
        checkOutput("nopDoneAt", 32'(doneAt),    32'd1);
        checkOutput("nopAccess", 32'(ramAccess), 32'd0);

        $display("[TB] reset during fill at word 4");
        preload = 1'b1;
        tick();
        preload = 1'b0;
        bus.cmd_op = OP_FILL; bus.cmd_addr = 6'd0; bus.cmd_len = 6'd9;
        bus.cmd_fill = 16'h5A5A; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick(); tick(); tick(); tick();
        checkOutput("rstMidAddr", 32'(ram_addr), 32'd4);
        checkOutput("rstMidEnHi", 32'(ram_en),   32'd1);
        CLR_n = 1'b0;
        #1;
        checkOutput("rstMidBusy", 32'(busy),   32'd0);
        checkOutput("rstMidEn",   32'(ram_en), 32'd0);
        tick(); tick();
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("rstMem%0d", i), 32'(mem[i]), 32'h5A5A);
        for (int i = 4; i < 10; i++)
            checkOutput($sformatf("rstMem%0d", i), 32'(mem[i]), 32'(16'hD000 + 16'(i)));
        CLR_n = 1'b1;
        tick();
        checkOutput("rstRelReady", 32'(bus.cmd_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Initiator side of the single-port 64×16 block RAM (en/we/CLR/addr/DI/DO port, one-cycle registered read, output clear). The block accepts burst commands over a valid/ready handshake and runs one of three operations: a read burst, a write burst streamed from a write-data channel, or a constant fill. It drives the RAM port cycle by cycle and returns read data on a response channel. It sits between a host/DMA-style client and one block RAM instance.

## Interface
- ADDR_W, 6, RAM address width (depth 2^ADDR_W, wrap modulo depth)
- DATA_W, 16, RAM data width
- CLK  in  1  clock, all state updates on rising edge
- CLR_n  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both high at a rising edge
- cmd_op  in  2  00 read burst, 01 write burst, 10 fill, 11 reserved (accepted, completes as no-op)
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W  burst length minus one (1..64 words)
- cmd_fill  in  DATA_W  fill value (op 10 only)
- wr_valid / wr_ready  in / out  1 / 1  write-data handshake
- wr_data  in  DATA_W  write word
- rd_valid  out  1  rd_data valid this cycle; no backpressure
- rd_data  out  DATA_W  read word (driven from ram_do)
- rd_last  out  1  with rd_valid, marks the final word of a burst
- abort  in  1  synchronous abort of the current burst
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a burst completes or is aborted
- ram_en, ram_we, ram_clr  out  1 each  RAM control
- ram_addr  out  ADDR_W  RAM address
- ram_di  out  DATA_W  RAM write data
- ram_do  in  DATA_W  RAM read data (valid the cycle after an en=1, we=0 access)

## Operation
- States: IDLE, READ, RD_DRAIN, WRITE, FILL, DONE.
- IDLE: cmd_ready=1. On cmd accept, latch the address into addr_q and cmd_len into cnt_q. Go to READ, WRITE, or FILL by op. Op 11 goes straight to DONE.
- READ: ram_en=1, ram_we=0, ram_addr=addr_q every cycle. On each cycle, addr_q+1 (wraps 63→0) and cnt_q-1. At cnt_q==0, go to RD_DRAIN.
- RD_DRAIN: one cycle so the last rd_valid can occur. Go to DONE.
- rd_valid and rd_last are registered copies of (READ) and (READ && cnt_q==0). rd_data = ram_do, combinational.
- WRITE: wr_ready=1. ram_en=ram_we=wr_valid, ram_addr=addr_q, ram_di=wr_data, combinational. Addr and count advance only on a wr_valid cycle. After the last accepted word, go to DONE. Stalls on wr_valid low are unbounded.
- FILL: ram_en=ram_we=1, ram_di=cmd_fill latched at accept. Advance every cycle. At cnt_q==0, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort in READ/WRITE/FILL:
  - The current cycle's RAM access still occurs.
  - Go to DONE next. ram_clr=1 in DONE so DO clears to 0.
  - A pending rd_valid from the abort cycle is still emitted.
  - abort in IDLE/DONE is ignored.
- ram_clr=0 in all other states. ram_* are 0 when not specified above.
- Reset values: state IDLE, addr_q 0, cnt_q 0, fill_q 0, rd_valid 0, rd_last 0, done 0, busy 0. cmd_ready is 1 out of reset.

## Timing
- Command accepted at edge E0. First RAM access is in the cycle after E0. First rd_valid is in the cycle after that.
- Read burst of N words: rd_valid for N consecutive cycles. done arrives 2 cycles after the last READ cycle. cmd_ready is low from E0 until IDLE returns, a total of N+2 cycles.
- Fill of N words: N consecutive write cycles, done in the following cycle.
- Write: one RAM write per cycle with wr_valid high. No buffering; wr_data goes straight to ram_di.
- Reset asserted mid-burst: outputs take their reset values immediately (asynchronous). No further RAM access occurs. A partially written range is left as is.
- Length 64 starting at any address covers every location exactly once (full wrap).

## Structure
- Shared package ram_pkg holds:
  - ADDR_W and DATA_W defaults.
  - Op codes OP_READ, OP_WRITE, OP_FILL, OP_NOP.
  - The state encoding.
- Single module, no sub-module. The address/count pair lives inline.
- The bench instantiates the existing block RAM to close the loop.

## Test plan
- Fill cmd addr=0, len=63, fill=0xA5A5 → 64 write cycles, done at cycle 65. A following read of 0..63 returns 0xA5A5 ×64, with rd_last on the 64th.
- Write addr=62, len=3, data 0x1111..0x4444 with wr_valid gaps → RAM[62]=0x1111, [63]=0x2222, [0]=0x3333, [1]=0x4444. The read-back order matches.
- Read addr=5, len=0 → one rd_valid with rd_last=1 two cycles after accept, then done one cycle later. cmd_ready is low for 3 cycles.
- Abort on the 3rd cycle of a 10-word read → exactly 3 rd_valid, done next cycle, ram_clr pulse with DO = 0.
- CLR_n low during a FILL at word 4 → busy/ram_en drop immediately. Words 0–3 are filled and word 4 onward is unchanged.
- cmd_op=11 → no RAM activity, done one cycle after accept.
